// File: rtl/frame_rd_timing_pkg.sv
// Shared definitions for the frame buffer read side: FSM state encoding and
// default bus widths.
package frame_buffer_def;

   localparam int DEF_DATA_WD = 32;
   localparam int DEF_H_WD    = 16;
   localparam int DEF_V_WD    = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEAD = 3'd1,
      ST_LINE = 3'd2,
      ST_GAP  = 3'd3,
      ST_TAIL = 3'd4
   } rd_state_e;

   function automatic int max3(int a, int b, int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/frame_rd_timing_if.sv
// Read port of the back-end buffer FIFO (standard FIFO: dout valid one cycle
// after rd).
interface frame_rd_timing_if import frame_buffer_def::*; #(
   parameter int DATA_WD = DEF_DATA_WD
);
   logic               rd;
   logic               empty;
   logic [DATA_WD-1:0] dout;

   modport master (output rd, input empty, input dout);
   modport slave  (input rd, output empty, output dout);
endinterface

// File: rtl/frame_rd_gap_cnt.sv
// Loadable down-counter; tc is high on the last cycle of a wait while enabled.
module frame_rd_gap_cnt #(
   parameter int WD = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          en,
   input  logic [WD-1:0] load_val,
   output logic          tc
);
   logic [WD-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)                  cnt <= '0;
      else if (load)              cnt <= load_val;
      else if (en && cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign tc = en && (cnt == '0);
endmodule

// File: rtl/frame_rd_timing.sv
// Read-side framer: drains the back FIFO into fval/dval/data framing with
// fixed lead, inter-line and tail guard gaps.
module frame_rd_timing import frame_buffer_def::*; #(
   parameter int DATA_WD  = DEF_DATA_WD,
   parameter int H_WD     = DEF_H_WD,
   parameter int V_WD     = DEF_V_WD,
   parameter int LEAD_CYC = 8,
   parameter int GAP_CYC  = 4,
   parameter int TAIL_CYC = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_start,
   input  logic [H_WD-1:0]    iv_width,
   input  logic [V_WD-1:0]    iv_height,
   frame_rd_timing_if.master  fifo,
   output logic               o_fval,
   output logic               o_dval,
   output logic [DATA_WD-1:0] ov_data,
   output logic               o_busy,
   output logic               o_frame_done
);
   localparam int GC_MAX = max3(LEAD_CYC, GAP_CYC, TAIL_CYC);
   localparam int GC_WD  = $clog2(GC_MAX + 1);
   localparam logic [GC_WD-1:0] LEAD_LD = GC_WD'(LEAD_CYC - 1);
   localparam logic [GC_WD-1:0] GAP_LD  = GC_WD'(GAP_CYC - 1);
   // TAIL state lasts TAIL_CYC-1 cycles; the IDLE cycle that follows is the
   // one where fval is low and frame_done pulses.
   localparam logic [GC_WD-1:0] TAIL_LD = GC_WD'(TAIL_CYC - 2);

   rd_state_e          state, state_nx;
   logic [H_WD-1:0]    wid_q, wcnt;
   logic [V_WD-1:0]    hgt_q, lcnt;
   logic               gc_load, gc_en, gc_tc;
   logic [GC_WD-1:0]   gc_val;
   logic               start_ok, rd, line_end, last_line;
   logic [DATA_WD-1:0] data_hold;

   assign start_ok  = i_start && (iv_width != '0) && (iv_height != '0);
   assign rd        = (state == ST_LINE) && !fifo.empty;
   assign line_end  = rd && (wcnt == wid_q - 1'b1);
   assign last_line = (lcnt == hgt_q - 1'b1);
   assign gc_en     = state inside {ST_LEAD, ST_GAP, ST_TAIL};

   frame_rd_gap_cnt #(.WD(GC_WD)) u_gap_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (gc_load),
      .en       (gc_en),
      .load_val (gc_val),
      .tc       (gc_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      gc_load  = 1'b0;
      gc_val   = LEAD_LD;
      case (state)
         ST_IDLE: if (start_ok) begin
            state_nx = ST_LEAD;
            gc_load  = 1'b1;
         end
         ST_LEAD: if (gc_tc) state_nx = ST_LINE;
         ST_LINE: if (line_end) begin
            gc_load = 1'b1;
            if (last_line) begin
               state_nx = ST_TAIL;
               gc_val   = TAIL_LD;
            end else begin
               state_nx = ST_GAP;
               gc_val   = GAP_LD;
            end
         end
         ST_GAP:  if (gc_tc) state_nx = ST_LINE;
         ST_TAIL: if (gc_tc) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wid_q        <= '0;
         hgt_q        <= '0;
         wcnt         <= '0;
         lcnt         <= '0;
         o_dval       <= 1'b0;
         o_frame_done <= 1'b0;
         data_hold    <= '0;
      end else begin
         o_dval       <= rd;
         o_frame_done <= (state == ST_TAIL) && gc_tc;
         if (o_dval) data_hold <= fifo.dout;
         if (state == ST_IDLE && start_ok) begin
            wid_q <= iv_width;
            hgt_q <= iv_height;
            wcnt  <= '0;
            lcnt  <= '0;
         end
         if (rd) wcnt <= line_end ? '0 : wcnt + 1'b1;
         if (state == ST_GAP && gc_tc) lcnt <= lcnt + 1'b1;
      end
   end

   // FIFO data arrives the cycle dval is high; pass it straight through so it
   // lines up with dval, and hold the captured word otherwise.
   assign ov_data = o_dval ? fifo.dout : data_hold;
   assign fifo.rd = rd;
   assign o_fval  = (state != ST_IDLE);
   assign o_busy  = (state != ST_IDLE);
endmodule

// File: tb/tb_frame_rd_timing.sv
// Scoreboard bench for frame_rd_timing: FIFO model feeds known words, the
// monitor checks every dval word and logs framing events for timing checks.
module tb_frame_rd_timing;
   import frame_buffer_def::*;

   localparam int DW = 32;
   localparam int HW = 16;
   localparam int VW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          i_start = 1'b0;
   logic [HW-1:0] iv_width = '0;
   logic [VW-1:0] iv_height = '0;
   logic          o_fval, o_dval, o_busy, o_frame_done;
   logic [DW-1:0] ov_data;

   frame_rd_timing_if #(.DATA_WD(DW)) fif ();

   frame_rd_timing #(
      .DATA_WD(DW), .H_WD(HW), .V_WD(VW),
      .LEAD_CYC(8), .GAP_CYC(4), .TAIL_CYC(8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_start      (i_start),
      .iv_width     (iv_width),
      .iv_height    (iv_height),
      .fifo         (fif),
      .o_fval       (o_fval),
      .o_dval       (o_dval),
      .ov_data      (ov_data),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] word(int i);
      return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   // FIFO model
   int   rd_idx = 0;
   int   wr_cnt = 0;
   logic stall = 1'b0;
   assign fif.empty = stall || (rd_idx >= wr_cnt);
   always @(posedge clk) begin
      if (fif.rd) begin
         fif.dout <= word(rd_idx);
         rd_idx   <= rd_idx + 1;
      end
   end

   // scoreboard / monitor
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_exp = '0;
   int rise_q[$], fall_q[$], done_q[$], dval_q[$];
   int rd_cnt = 0;
   logic fval_d = 1'b0;

   always @(negedge clk) begin
      if (o_fval && !fval_d) rise_q.push_back(cyc);
      if (!o_fval && fval_d) fall_q.push_back(cyc);
      fval_d = o_fval;
      if (o_frame_done) done_q.push_back(cyc);
      if (fif.rd) rd_cnt++;
      if (o_dval) begin
         dval_q.push_back(cyc);
         chk("dval_in_fval", {63'd0, o_fval}, 64'd1);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL data_extra: got %h, no word expected", ov_data);
         end else begin
            last_exp = exp_q.pop_front();
            chk("data", {32'd0, ov_data}, {32'd0, last_exp});
         end
      end
   end

   int s_cyc;

   task automatic clear_logs();
      rise_q.delete(); fall_q.delete(); done_q.delete(); dval_q.delete();
      rd_cnt = 0;
   endtask

   task automatic load(int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(word(wr_cnt));
         wr_cnt++;
      end
   endtask

   task automatic start_frame(int w, int h);
      @(posedge clk); #1;
      iv_width  = HW'(w);
      iv_height = VW'(h);
      i_start   = 1'b1;
      s_cyc     = cyc;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done(int n, int lim);
      int k, nd;
      k = 0; nd = 0;
      while (nd < n && k < lim) begin
         @(negedge clk);
         k++;
         if (o_frame_done) nd++;
      end
      chk("frame_done_seen", 64'(nd), 64'(n));
      @(negedge clk);
   endtask

   initial begin
      int k, nr, busy_seen;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_fval", {63'd0, o_fval}, 64'd0);
      chk("rst_dval", {63'd0, o_dval}, 64'd0);
      chk("rst_busy", {63'd0, o_busy}, 64'd0);
      chk("rst_done", {63'd0, o_frame_done}, 64'd0);
      chk("rst_rd", {63'd0, fif.rd}, 64'd0);
      chk("rst_data", {32'd0, ov_data}, 64'd0);

      // basic frame 4x2
      clear_logs(); load(8); start_frame(4, 2); wait_done(1, 100);
      chk("b_rise_cnt", 64'(rise_q.size()), 64'd1);
      chk("b_rise_lat", 64'(rise_q[0] - s_cyc), 64'd1);
      chk("b_nwords", 64'(dval_q.size()), 64'd8);
      chk("b_first_dval", 64'(dval_q[0] - rise_q[0]), 64'd9);
      chk("b_burst0", 64'(dval_q[3] - dval_q[0]), 64'd3);
      chk("b_line_gap", 64'(dval_q[4] - dval_q[3]), 64'd5);
      chk("b_burst1", 64'(dval_q[7] - dval_q[4]), 64'd3);
      chk("b_tail", 64'(fall_q[0] - dval_q[7]), 64'd7);
      chk("b_done_at_fall", 64'(done_q[0]), 64'(fall_q[0]));
      chk("b_done_cnt", 64'(done_q.size()), 64'd1);
      chk("b_exp_left", 64'(exp_q.size()), 64'd0);
      chk("b_data_hold", {32'd0, ov_data}, {32'd0, word(7)});
      chk("b_busy_end", {63'd0, o_busy}, 64'd0);

      // underrun: 5 empty cycles after word 3
      clear_logs(); load(8); start_frame(8, 1);
      k = 0; nr = 0;
      while (nr < 3 && k < 100) begin
         @(negedge clk); k++;
         if (fif.rd) nr++;
      end
      chk("u_reads_seen", 64'(nr), 64'd3);
      @(posedge clk); #1 stall = 1'b1;
      repeat (5) @(posedge clk);
      #1 stall = 1'b0;
      wait_done(1, 100);
      chk("u_nwords", 64'(dval_q.size()), 64'd8);
      chk("u_pre", 64'(dval_q[2] - dval_q[0]), 64'd2);
      chk("u_stall_gap", 64'(dval_q[3] - dval_q[2]), 64'd6);
      chk("u_fall_cnt", 64'(fall_q.size()), 64'd1);
      chk("u_tail", 64'(fall_q[0] - dval_q[7]), 64'd7);

      // zero-size requests
      clear_logs(); busy_seen = 0;
      @(posedge clk); #1 iv_width = 0; iv_height = 3; i_start = 1'b1;
      repeat (4) begin @(negedge clk); if (o_busy) busy_seen++; end
      @(posedge clk); #1 iv_width = 5; iv_height = 0;
      repeat (4) begin @(negedge clk); if (o_busy) busy_seen++; end
      @(posedge clk); #1 i_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("z_busy", 64'(busy_seen), 64'd0);
      chk("z_reads", 64'(rd_cnt), 64'd0);
      chk("z_fval", 64'(rise_q.size()), 64'd0);

      // reset during word 2 of the first line
      clear_logs(); load(8); start_frame(4, 2);
      k = 0; nr = 0;
      while (nr < 2 && k < 100) begin
         @(negedge clk); k++;
         if (o_dval) nr++;
      end
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("r_fval", {63'd0, o_fval}, 64'd0);
      chk("r_dval", {63'd0, o_dval}, 64'd0);
      chk("r_rd", {63'd0, fif.rd}, 64'd0);
      chk("r_busy", {63'd0, o_busy}, 64'd0);
      repeat (30) @(negedge clk);
      chk("r_no_done", 64'(done_q.size()), 64'd0);
      exp_q.delete();
      wr_cnt = rd_idx;
      clear_logs(); load(8); start_frame(4, 2); wait_done(1, 100);
      chk("r2_nwords", 64'(dval_q.size()), 64'd8);
      chk("r2_first_dval", 64'(dval_q[0] - rise_q[0]), 64'd9);
      chk("r2_done_at_fall", 64'(done_q[0]), 64'(fall_q[0]));
      chk("r2_exp_left", 64'(exp_q.size()), 64'd0);

      // back-to-back 1x1 frames with i_start held
      clear_logs(); load(2);
      @(posedge clk); #1 iv_width = 1; iv_height = 1; i_start = 1'b1;
      k = 0; nr = 0;
      while (nr < 2 && k < 200) begin
         @(negedge clk); k++;
         if (o_frame_done) nr++;
      end
      i_start = 1'b0;
      chk("bb_dones", 64'(nr), 64'd2);
      repeat (5) @(negedge clk);
      chk("bb_rise_cnt", 64'(rise_q.size()), 64'd2);
      chk("bb_len", 64'(fall_q[0] - rise_q[0]), 64'd16);
      chk("bb_low_gap", 64'(rise_q[1] - fall_q[0]), 64'd1);
      chk("bb_nwords", 64'(dval_q.size()), 64'd2);
      chk("bb_exp_left", 64'(exp_q.size()), 64'd0);

      // size latch and ignored mid-frame start
      clear_logs(); load(4); start_frame(4, 1);
      repeat (3) @(posedge clk);
      #1 iv_width = 2; i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      wait_done(1, 100);
      repeat (20) @(negedge clk);
      chk("sl_nwords", 64'(dval_q.size()), 64'd4);
      chk("sl_burst", 64'(dval_q[3] - dval_q[0]), 64'd3);
      chk("sl_rise_cnt", 64'(rise_q.size()), 64'd1);
      chk("sl_exp_left", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
